vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Upstream stage of the pixel pipeline. Generates the pixel clock-enable, the raster counters `pixel_x`/`pixel_y`, and VGA `hsync`/`vsync`/`video_on`.
- The draw/tile-lookup stage consumes `pixel_x`/`pixel_y`. Its name-RAM and tile-ROM reads add pipeline latency.
- The block also supplies copies of `hsync`/`vsync`/`video_on` delayed by `PIPE_DELAY` pixel ticks. These line up with the RGB produced downstream at the DAC/connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (≥1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 2, pixel-tick delay applied to the `_d` outputs (0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pixel_tick  out  1  one-clk pulse, once every CLK_DIV clks
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- video_on  out  1  pixel_x<H_ACTIVE && pixel_y<V_ACTIVE
- hsync  out  1  horizontal sync, aligned to pixel_x
- vsync  out  1  vertical sync, aligned to pixel_y
- line_start  out  1  one-clk pulse when pixel_x wraps to 0
- frame_start  out  1  one-clk pulse when (pixel_x,pixel_y) wraps to (0,0)
- hsync_d  out  1  hsync delayed PIPE_DELAY ticks
- vsync_d  out  1  vsync delayed PIPE_DELAY ticks
- video_on_d  out  1  video_on delayed PIPE_DELAY ticks

Behaviour:
- Derived widths:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = 525.
  - Both totals must fit in 10 bits.
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst is high:
  - divider = 0.
  - pixel_x = pixel_y = 0.
  - video_on = 0.
  - hsync = vsync = ~SYNC_POL.
  - All pulses = 0.
  - All delay stages hold video 0 and sync inactive.
  - Reset mid-frame aborts immediately; there is no completion of the line.
- Divider:
  - Counts 0..CLK_DIV-1.
  - pixel_tick is high when divider == CLK_DIV-1.
  - With CLK_DIV = 1, pixel_tick is constant 1 after reset.
- Counters advance only on clk edges where pixel_tick = 1:
  - pixel_x increments. When pixel_x == H_TOTAL-1 it wraps to 0.
  - pixel_y increments on that wrap. When pixel_y == V_TOTAL-1 it wraps to 0 at the same time.
- Decoded outputs (video_on, hsync, vsync) are registered from the next-state counter values. They therefore change on the same edge as pixel_x/pixel_y, with zero relative skew.
  - hsync active for pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - vsync active for pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491].
- First pixel after reset: (0,0) is presented with video_on = 0 until the first tick. The first tick moves the counters to (1,0) with video_on = 1. Pixel (0,0) of frame 0 is blanked; this is accepted.
- line_start / frame_start:
  - Registered, high for exactly the one clk following the wrap edge.
  - frame_start implies line_start.
- Delay line:
  - PIPE_DELAY-stage shift register, shifted only on pixel_tick.
  - PIPE_DELAY = 0 makes the `_d` outputs identical to the undelayed outputs.
  - No glitch at frame wrap: sync activity is continuous across the wrap.

Decomposition:
- Shared package `vga_timing_pkg`:
  - 640x480@60 timing constants.
  - Derived H_TOTAL/V_TOTAL and the sync window bounds.
  - SYNC_POL default.
  - Reused by the draw stage for active-area compares.
- Sub-module `sync_delay_line`:
  - Parameters WIDTH = 3 and DEPTH = PIPE_DELAY.
  - Inputs: clk, rst, enable (pixel_tick), reset value.
  - Instantiated once for {hsync, vsync, video_on}.

Test Plan:
- Reset held 5 clks, then released → pixel_x = pixel_y = 0, hsync = vsync = 1, video_on = 0. The first pixel_tick appears at clk 2 after release (CLK_DIV = 2), and the counters then read (1,0) with video_on = 1.
- Run one full line → pixel_x reaches 799 and wraps to 0. pixel_y becomes 1 and line_start pulses for 1 clk. hsync is low for exactly 96 ticks, starting at pixel_x = 656. video_on is low for pixel_x ≥ 640.
- Run one full frame (840000 clks) → vsync is low on lines 490–491 only (1600 ticks). pixel_y wraps 524→0 and frame_start pulses once, simultaneously with line_start.
- PIPE_DELAY = 2 → hsync_d/vsync_d/video_on_d equal hsync/vsync/video_on shifted by exactly 2 ticks (4 clks). Rebuild with PIPE_DELAY = 0 → the `_d` outputs are identical to the undelayed outputs.
- Assert rst asynchronously mid-line (pixel_x = 700, inside hsync) → all outputs reach reset values without a clk edge. After release, counting restarts from (0,0).
- CLK_DIV = 1, SYNC_POL = 1 → pixel_tick is constant high. hsync is high for pixel_x 656–751, and a frame takes 420000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, derived totals/sync windows and a window-compare helper
package vga_timing_pkg;
   typedef logic [9:0] coord_t;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_FIRST = H_ACTIVE + H_FP;
   localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
   localparam int VS_FIRST = V_ACTIVE + V_FP;
   localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
   localparam logic SYNC_POL = 1'b0;
   function automatic logic in_range(coord_t v, int lo, int hi);
      return int'(v) >= lo && int'(v) <= hi;
   endfunction
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage enable-gated shift register; DEPTH=0 is a straight wire
module sync_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_rst_val,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = ^{clk, rst, i_en, i_rst_val};
      assign o_q = i_d;
   end else begin : g_shift
      logic [WIDTH-1:0] r_sr [DEPTH];
      always_ff @(posedge clk or posedge rst)
         if (rst)
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= i_rst_val;
         else if (i_en) begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
         end
      assign o_q = r_sr[DEPTH-1];
   end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel divider, raster counters, registered sync/blank and pipeline-delayed copies
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
   parameter int   H_FP       = vga_timing_pkg::H_FP,
   parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int   H_BP       = vga_timing_pkg::H_BP,
   parameter int   V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
   parameter int   V_FP       = vga_timing_pkg::V_FP,
   parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int   V_BP       = vga_timing_pkg::V_BP,
   parameter int   CLK_DIV    = 2,
   parameter logic SYNC_POL   = vga_timing_pkg::SYNC_POL,
   parameter int   PIPE_DELAY = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pixel_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start,
   output logic       hsync_d,
   output logic       vsync_d,
   output logic       video_on_d
);
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW    = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   logic [DW-1:0] r_div, w_div_nxt;
   logic          r_tick, r_vid, r_hs, r_vs, r_ls, r_fs;
   coord_t        r_x, r_y, w_x_nxt, w_y_nxt;
   logic          w_x_wrap, w_y_wrap;
   logic [2:0]    w_dly;
   always_comb begin
      w_div_nxt = (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
      w_x_wrap  = r_x == 10'(H_TOT - 1);
      w_y_wrap  = r_y == 10'(V_TOT - 1);
      w_x_nxt   = w_x_wrap ? '0 : r_x + 1'b1;
      w_y_nxt   = w_x_wrap ? (w_y_wrap ? '0 : r_y + 1'b1) : r_y;
   end
   // decodes are taken from the next-state counters so they flip on the same edge as x/y
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_div  <= '0;
         r_tick <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
         r_vid  <= 1'b0;
         r_hs   <= ~SYNC_POL;
         r_vs   <= ~SYNC_POL;
         r_ls   <= 1'b0;
         r_fs   <= 1'b0;
      end else begin
         r_div  <= w_div_nxt;
         r_tick <= w_div_nxt == DW'(CLK_DIV - 1);
         r_ls   <= r_tick && w_x_wrap;
         r_fs   <= r_tick && w_x_wrap && w_y_wrap;
         if (r_tick) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_vid <= in_range(w_x_nxt, 0, H_ACTIVE - 1) && in_range(w_y_nxt, 0, V_ACTIVE - 1);
            r_hs  <= in_range(w_x_nxt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
            r_vs  <= in_range(w_y_nxt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
         end
      end
   sync_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY)) u_dly (
      .clk       (clk),
      .rst       (rst),
      .i_en      (r_tick),
      .i_rst_val ({~SYNC_POL, ~SYNC_POL, 1'b0}),
      .i_d       ({r_hs, r_vs, r_vid}),
      .o_q       (w_dly)
   );
   assign pixel_tick  = r_tick;
   assign pixel_x     = r_x;
   assign pixel_y     = r_y;
   assign video_on    = r_vid;
   assign hsync       = r_hs;
   assign vsync       = r_vs;
   assign line_start  = r_ls;
   assign frame_start = r_fs;
   assign {hsync_d, vsync_d, video_on_d} = w_dly;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three configurations checked every cycle against an arithmetic raster model
module tb_vga_sync_gen;
   typedef struct packed {int ha, fp, sw, bp, va, vfp, vsw, vbp, div, pol, dly;} cfg_t;
   typedef logic [28:0] ov_t;
   localparam cfg_t CA = '{ha:640, fp:16, sw:96, bp:48, va:480, vfp:10, vsw:2, vbp:33, div:2, pol:0, dly:2};
   localparam cfg_t CB = '{ha:4, fp:1, sw:2, bp:1, va:3, vfp:1, vsw:1, vbp:1, div:1, pol:1, dly:0};
   localparam cfg_t CC = '{ha:5, fp:2, sw:3, bp:2, va:2, vfp:1, vsw:2, vbp:1, div:3, pol:0, dly:5};
   logic clk = 1'b0, rst = 1'b1;
   logic tk [3], vid [3], hs [3], vs [3], ls [3], fs [3], hsd [3], vsd [3], vidd [3];
   logic [9:0] px [3], py [3];
   int n, tests = 0, fails = 0;
   cfg_t cfgs [3] = '{CA, CB, CC};
   always #5 clk = ~clk;

   vga_sync_gen u_a (
      .clk(clk), .rst(rst), .pixel_tick(tk[0]), .pixel_x(px[0]), .pixel_y(py[0]), .video_on(vid[0]),
      .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0]),
      .hsync_d(hsd[0]), .vsync_d(vsd[0]), .video_on_d(vidd[0]));
   vga_sync_gen #(.H_ACTIVE(CB.ha), .H_FP(CB.fp), .H_SYNC(CB.sw), .H_BP(CB.bp), .V_ACTIVE(CB.va),
      .V_FP(CB.vfp), .V_SYNC(CB.vsw), .V_BP(CB.vbp), .CLK_DIV(CB.div), .SYNC_POL(CB.pol[0]),
      .PIPE_DELAY(CB.dly)) u_b (
      .clk(clk), .rst(rst), .pixel_tick(tk[1]), .pixel_x(px[1]), .pixel_y(py[1]), .video_on(vid[1]),
      .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1]),
      .hsync_d(hsd[1]), .vsync_d(vsd[1]), .video_on_d(vidd[1]));
   vga_sync_gen #(.H_ACTIVE(CC.ha), .H_FP(CC.fp), .H_SYNC(CC.sw), .H_BP(CC.bp), .V_ACTIVE(CC.va),
      .V_FP(CC.vfp), .V_SYNC(CC.vsw), .V_BP(CC.vbp), .CLK_DIV(CC.div), .SYNC_POL(CC.pol[0]),
      .PIPE_DELAY(CC.dly)) u_c (
      .clk(clk), .rst(rst), .pixel_tick(tk[2]), .pixel_x(px[2]), .pixel_y(py[2]), .video_on(vid[2]),
      .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2]),
      .hsync_d(hsd[2]), .vsync_d(vsd[2]), .video_on_d(vidd[2]));

   // clk edges seen since the last reset release
   always @(posedge clk or posedge rst) n <= rst ? 0 : n + 1;

   // {hsync, vsync, video_on} for the pixel reached after t ticks; t<=0 means nothing shown yet
   function automatic logic [2:0] dec(cfg_t c, int t);
      int ht = c.ha + c.fp + c.sw + c.bp;
      int vt = c.va + c.vfp + c.vsw + c.vbp;
      logic pol = c.pol[0];
      int p, x, y;
      if (t <= 0) return {~pol, ~pol, 1'b0};
      p = t % (ht * vt);
      x = p % ht;
      y = p / ht;
      return {(x >= c.ha + c.fp && x < c.ha + c.fp + c.sw) ? pol : ~pol,
              (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? pol : ~pol,
              x < c.ha && y < c.va};
   endfunction

   function automatic ov_t model(cfg_t c, int e, logic r);
      int ht = c.ha + c.fp + c.sw + c.bp;
      int vt = c.va + c.vfp + c.vsw + c.vbp;
      logic pol = c.pol[0];
      int t, p, x, y;
      logic tick, tick_edge, l, f;
      logic [2:0] cur, del;
      if (r) return {1'b0, 10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, ~pol, ~pol, 1'b0};
      t = (c.div == 1) ? (e > 0 ? e - 1 : 0) : e / c.div;
      tick = e > 0 && (e % c.div) == c.div - 1;
      tick_edge = e > 1 && (e % c.div) == 0;
      p = t % (ht * vt);
      x = p % ht;
      y = p / ht;
      cur = dec(c, t);
      del = dec(c, t - c.dly);
      l = tick_edge && x == 0;
      f = l && y == 0;
      return {tick, 10'(x), 10'(y), cur[0], cur[2], cur[1], l, f, del};
   endfunction

   task automatic chk(string nm, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      for (int i = 0; i < 3; i++) begin
         ov_t act, exp;
         act = {tk[i], px[i], py[i], vid[i], hs[i], vs[i], ls[i], fs[i], hsd[i], vsd[i], vidd[i]};
         exp = model(cfgs[i], n, rst);
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL model_dut%0d t=%0t n=%0d actual=%h required=%h", i, $time, n, act, exp);
         end
      end

   initial begin
      int hl = 0, vl = 0, lsn = 0, first_hs = -1, lsx = -1, lsy = -1;
      int fsb = 0, vsb = 0, tkb = 0, fswo = 0, k = 0, d;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_x", px[0], 0);
      chk("rst_y", py[0], 0);
      chk("rst_hs", hs[0], 1);
      chk("rst_vs", vs[0], 1);
      chk("rst_vid", vid[0], 0);
      @(negedge clk);
      chk("first_tick", tk[0], 1);
      chk("x_before_tick", px[0], 0);
      @(negedge clk);
      chk("first_x", px[0], 1);
      chk("first_vid", vid[0], 1);
      for (int j = 0; j < 1600; j++) begin
         @(negedge clk);
         if (!hs[0]) begin
            if (hl == 0) first_hs = px[0];
            hl++;
         end
         if (!vid[0]) vl++;
         if (ls[0]) begin
            lsn++;
            lsx = px[0];
            lsy = py[0];
         end
         fsb += fs[1];
         vsb += vs[1];
         tkb += tk[1];
         if (fs[1] && !ls[1]) fswo++;
      end
      chk("hs_low_clks", hl, 192);
      chk("hs_first_x", first_hs, 656);
      chk("blank_clks", vl, 320);
      chk("line_start_cnt", lsn, 1);
      chk("line_start_x", lsx, 0);
      chk("line_start_y", lsy, 1);
      chk("b_frames", fsb, 33);
      chk("b_vs_high_clks", vsb, 264);
      chk("b_tick_clks", tkb, 1600);
      chk("b_fs_without_ls", fswo, 0);
      while (px[0] != 10'd700 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk("x700_reached", px[0], 700);
      chk("hs_at_700", hs[0], 0);
      chk("hsd_at_700", hsd[0], 0);
      #2 rst = 1'b1;
      #1;
      chk("async_x", px[0], 0);
      chk("async_y", py[0], 0);
      chk("async_hs", hs[0], 1);
      chk("async_hsd", hsd[0], 1);
      chk("async_tick", tk[0], 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (25) begin
         repeat ($urandom_range(1, 300)) @(posedge clk);
         d = $urandom_range(1, 4);
         #(d) rst = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         d = $urandom_range(1, 4);
         #(d) rst = 1'b0;
      end
      repeat (400) @(posedge clk);
      #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
